rom_arbiter: RTL and testbench

//   Shares the single-read-port instruction ROM between two requesters:

---
 rtl/rom_arbiter.sv | 120 ++++++++++++
 tb/tb_rom_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one negedge-registered instruction ROM read port
// between fetch (port 0) and constant-load (port 1); optional address check via ROM_ARB_CHECK_EN.
module rom_arbiter #(
    parameter int DEPTH      = 1024,
    parameter int FIRST_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    output logic [31:0] p0_rdata,
    output logic        p0_rvalid,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    output logic [31:0] p1_rdata,
    output logic        p1_rvalid,
    output logic        p1_err,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_rd,
    output logic        busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nx;
    logic        owner, owner_nx;
    logic        rr, rr_nx;
    logic        bad, bad_nx;
    logic [31:0] rom_addr_nx;
    logic [31:0] p0_rdata_nx, p1_rdata_nx;
    logic        p0_rvalid_nx, p1_rvalid_nx;
    logic        p0_err_nx, p1_err_nx;
    logic        winner;
    logic [31:0] win_addr;
    logic        win_bad;

    // A lone requester wins outright; a tie goes to the port the pointer names.
    assign winner   = (p0_req && p1_req) ? rr : p1_req;
    assign win_addr = winner ? p1_addr : p0_addr;

`ifdef ROM_ARB_CHECK_EN
    assign win_bad = (win_addr[1:0] != 2'b00) || ({2'b00, win_addr[31:2]} >= 32'(DEPTH));
`else
    assign win_bad = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_nx     = state;
        owner_nx     = owner;
        rr_nx        = rr;
        bad_nx       = bad;
        rom_addr_nx  = rom_addr;
        p0_rdata_nx  = p0_rdata;
        p1_rdata_nx  = p1_rdata;
        p0_err_nx    = p0_err;
        p1_err_nx    = p1_err;
        p0_rvalid_nx = 1'b0;
        p1_rvalid_nx = 1'b0;

        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_nx = BUSY;
                    owner_nx = winner;
                    rr_nx    = ~winner;
                    bad_nx   = win_bad;
                    if (!win_bad) rom_addr_nx = win_addr;
                end
            end
            BUSY: begin
                // ROM sampled rom_addr on the negedge in between; its word is valid now.
                state_nx = IDLE;
                if (owner) begin
                    p1_rdata_nx  = bad ? 32'h0 : rom_rd;
                    p1_err_nx    = bad;
                    p1_rvalid_nx = 1'b1;
                end else begin
                    p0_rdata_nx  = bad ? 32'h0 : rom_rd;
                    p0_err_nx    = bad;
                    p0_rvalid_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            rr        <= 1'(FIRST_PRIO);
            bad       <= 1'b0;
            rom_addr  <= 32'h0;
            p0_rdata  <= 32'h0;
            p1_rdata  <= 32'h0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state     <= state_nx;
            owner     <= owner_nx;
            rr        <= rr_nx;
            bad       <= bad_nx;
            rom_addr  <= rom_addr_nx;
            p0_rdata  <= p0_rdata_nx;
            p1_rdata  <= p1_rdata_nx;
            p0_rvalid <= p0_rvalid_nx;
            p1_rvalid <= p1_rvalid_nx;
            p0_err    <= p0_err_nx;
            p1_err    <= p1_err_nx;
            busy      <= (state_nx == BUSY);
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations. Honours ROM_ARB_CHECK_EN if defined.
module tb_rom_arbiter;
    localparam int DEPTH      = 1024;
    localparam int FIRST_PRIO = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p0_req = 1'b0, p1_req = 1'b0;
    logic [31:0] p0_addr = 32'h0, p1_addr = 32'h0;
    logic [31:0] p0_rdata, p1_rdata, rom_addr, rom_rd;
    logic        p0_rvalid, p1_rvalid, p0_err, p1_err, busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    rom_arbiter #(.DEPTH(DEPTH), .FIRST_PRIO(FIRST_PRIO)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid), .p0_err(p0_err),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid), .p1_err(p1_err),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [DEPTH];

    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        if (idx < 32'(DEPTH)) return rom[int'(idx)];
        return 32'hBAD0_0000 ^ idx;
    endfunction

    function automatic bit addr_bad(input logic [31:0] a);
`ifdef ROM_ARB_CHECK_EN
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
`else
        return 1'b0;
`endif
    endfunction

    // ROM: registered read on the falling edge
    always @(negedge clk) rom_rd <= rom_word({2'b00, rom_addr[31:2]});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one access is either pending or not; it completes one edge after grant.
    logic [31:0] exp_rdata [2];
    bit          exp_valid [2];
    bit          exp_err   [2];
    logic [31:0] exp_rom_addr;
    bit          m_pending, m_port, m_rr;
    logic [31:0] m_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_rdata[0] = 0; exp_rdata[1] = 0;
            exp_valid[0] = 0; exp_valid[1] = 0;
            exp_err[0]   = 0; exp_err[1]   = 0;
            exp_rom_addr = 0;
            m_pending    = 0;
            m_rr         = 1'(FIRST_PRIO);
        end else begin
            exp_valid[0] = 0;
            exp_valid[1] = 0;
            if (m_pending) begin
                m_pending         = 0;
                exp_valid[m_port] = 1;
                exp_err[m_port]   = addr_bad(m_addr);
                exp_rdata[m_port] = addr_bad(m_addr) ? 32'h0 : rom_word({2'b00, m_addr[31:2]});
            end else if (p0_req || p1_req) begin
                if (p0_req && p1_req) m_port = m_rr;
                else                  m_port = p1_req;
                m_addr    = m_port ? p1_addr : p0_addr;
                m_rr      = !m_port;
                m_pending = 1;
                if (!addr_bad(m_addr)) exp_rom_addr = m_addr;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (started && !rst) begin
            check("p0_rvalid", p0_rvalid, exp_valid[0]);
            check("p1_rvalid", p1_rvalid, exp_valid[1]);
            check("p0_rdata",  p0_rdata,  exp_rdata[0]);
            check("p1_rdata",  p1_rdata,  exp_rdata[1]);
            check("p0_err",    p0_err,    exp_err[0]);
            check("p1_err",    p1_err,    exp_err[1]);
            check("rom_addr",  rom_addr,  exp_rom_addr);
            check("busy",      busy,      m_pending);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_p0_rdata"},  p0_rdata,  0);
        check({tag, "_p1_rdata"},  p1_rdata,  0);
        check({tag, "_p0_rvalid"}, p0_rvalid, 0);
        check({tag, "_p1_rvalid"}, p1_rvalid, 0);
        check({tag, "_p0_err"},    p0_err,    0);
        check({tag, "_p1_err"},    p1_err,    0);
        check({tag, "_rom_addr"},  rom_addr,  0);
        check({tag, "_busy"},      busy,      0);
    endtask

    // Async reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #2;
        check_all_zero(tag);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int port, input int budget, output int cycles);
        cycles = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if ((port == 0 && p0_rvalid) || (port == 1 && p1_rvalid)) begin
                cycles = c;
                break;
            end
        end
        if (cycles < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout waiting for p%0d_rvalid: got none expected pulse within %0d cycles", port, budget);
        end
    endtask

    int          cyc;
    int          order [8];
    logic [31:0] words [3];
    int          gaps  [3];

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'h1000_0000 + 32'(i);
        rom[2] = 32'hDEAD_BEEF;

        #1;
        pulse_reset("reset");
        started = 1'b1;

        // 1: single fetch from 0x8
        tick();
        p0_addr = 32'h8;
        p0_req  = 1'b1;
        wait_valid(0, 4, cyc);
        p0_req = 1'b0;
        check("t1_latency",  32'(cyc), 2);
        check("t1_rdata",    p0_rdata, 32'hDEAD_BEEF);
        check("t1_err",      p0_err, 0);
        check("t1_rom_addr", rom_addr, 32'h8);
        check("t1_p1_valid", p1_rvalid, 0);
        check("t1_p1_rdata", p1_rdata, 0);
        tick();
        check("t1_valid_clr", p0_rvalid, 0);

        // 2: simultaneous requests from reset, grants alternate
        pulse_reset("t2_reset");
        p0_addr = 32'h0;
        p1_addr = 32'h4;
        p0_req  = 1'b1;
        p1_req  = 1'b1;
        for (int n = 0; n < 8; n++) begin
            int c;
            c = 0;
            do begin
                tick();
                c++;
            end while (!(p0_rvalid || p1_rvalid) && c < 4);
            if (!(p0_rvalid || p1_rvalid)) begin
                n_tests++;
                n_fail++;
                $display("FAIL t2_timeout: got no rvalid expected one within 4 cycles");
            end
            order[n] = p1_rvalid ? 1 : 0;
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        for (int n = 0; n < 8; n++) check($sformatf("t2_order%0d", n), 32'(order[n]), 32'(n % 2));
        check("t2_p0_rdata", p0_rdata, 32'h1000_0000);
        check("t2_p1_rdata", p1_rdata, 32'h1000_0001);
        tick();

        // 3: streaming on port 1 from 0x10
        p1_addr = 32'h10;
        p1_req  = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wait_valid(1, 4, gaps[n]);
            words[n] = p1_rdata;
            if (n == 2) p1_req = 1'b0;
            else        p1_addr = p1_addr + 32'h4;
        end
        for (int n = 0; n < 3; n++) begin
            check($sformatf("t3_word%0d", n), words[n], 32'h1000_0004 + 32'(n));
            check($sformatf("t3_gap%0d", n), 32'(gaps[n]), 2);
        end
        tick();

        // 4: reset mid-access, then a tie must go to FIRST_PRIO
        p0_addr = 32'h20;
        p0_req  = 1'b1;
        tick();
        check("t4_busy", busy, 1);
        p0_req = 1'b0;
        pulse_reset("t4_reset");
        tick();
        check("t4_no_pulse", p0_rvalid, 0);
        tick();
        check("t4_no_pulse2", p0_rvalid, 0);
        p0_addr = 32'hC;
        p1_addr = 32'h20;
        p0_req  = 1'b1;
        p1_req  = 1'b1;
        wait_valid(0, 4, cyc);
        p0_req = 1'b0;
        p1_req = 1'b0;
        check("t4_p0_first", p0_rvalid, 1);
        check("t4_p1_idle",  p1_rvalid, 0);
        check("t4_rdata",    p0_rdata, 32'h1000_0003);
        tick();
        tick();

        // 5: misaligned / out-of-range addresses
        p0_addr = 32'h6;
        p0_req  = 1'b1;
        wait_valid(0, 4, cyc);
        p0_req = 1'b0;
`ifdef ROM_ARB_CHECK_EN
        check("t5_err",      p0_err, 1);
        check("t5_rdata",    p0_rdata, 0);
        check("t5_rom_addr", rom_addr, 32'hC);
        tick();
        p0_addr = 32'(DEPTH * 4);
        p0_req  = 1'b1;
        wait_valid(0, 4, cyc);
        p0_req = 1'b0;
        check("t5_range_err",   p0_err, 1);
        check("t5_range_rdata", p0_rdata, 0);
`else
        check("t5_err",      p0_err, 0);
        check("t5_rdata",    p0_rdata, 32'h1000_0001);
        check("t5_rom_addr", rom_addr, 32'h6);
`endif
        tick();

        // 6: request dropped right after grant still completes once
        p0_addr = 32'h14;
        p0_req  = 1'b1;
        tick();
        check("t6_busy", busy, 1);
        p0_req = 1'b0;
        tick();
        check("t6_pulse", p0_rvalid, 1);
        check("t6_rdata", p0_rdata, 32'h1000_0005);
        tick();
        check("t6_pulse_clr", p0_rvalid, 0);
        check("t6_idle",      busy, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
